aes_decipher_ctrl: RTL and testbench

//  Iterative AES decipher datapath and sequencer; sits between the host-side block interface and the key memory.

---
 rtl/aes_decipher_ctrl_pkg.sv | 53 +++++
 rtl/aes_decipher_ctrl_if.sv | 11 +
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes_decipher_ctrl.sv | 126 ++++++++++++
 tb/tb_aes_decipher_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_decipher_ctrl_pkg.sv
// Shared AES decipher definitions: key-length encodings, round counts and GF(2^8) helpers.
package aes_decipher_ctrl_pkg;

  localparam logic [1:0] AES_128 = 2'd0;
  localparam logic [1:0] AES_192 = 2'd1;
  localparam logic [1:0] AES_256 = 2'd2;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Encoding 3 is undefined and falls back to AES-128.
  function automatic logic [3:0] num_rounds(logic [1:0] keylen);
    case (keylen)
      AES_192: return NR_192;
      AES_256: return NR_256;
      default: return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gm09(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_decipher_ctrl_if.sv
// Host-side block interface of the AES decipher: start/ciphertext in, plaintext/ready out.
interface aes_decipher_ctrl_if;
  logic         next;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (output next, keylen, block, input new_block, ready);
  modport slave  (input next, keylen, block, output new_block, ready);
endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, computed as GF(2^8) inversion of the inverse affine transform.
module aes_inv_sbox
  import aes_decipher_ctrl_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] affine_inv;

  assign affine_inv = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]} ^
                      {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
  assign out_byte   = gf_inv(affine_inv);

endmodule

// File: rtl/aes_decipher_ctrl.sv
// Iterative AES decipher: one round per 6 cycles, InvSubBytes word-serial through 4 S-boxes.
module aes_decipher_ctrl
  import aes_decipher_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  aes_decipher_ctrl_if.slave  host,
  output logic [3:0]          round_key_addr,
  input  logic [127:0]        round_key
);

  typedef enum logic [2:0] {StIdle, StInit, StIsr, StIsb, StArk} state_e;

  state_e         state_q, state_d;
  logic [127:0]   block_q, block_d;
  logic [3:0]     round_ctr_q, round_ctr_d;
  logic [1:0]     sword_ctr_q, sword_ctr_d;
  logic [31:0]    sword_in, sword_out;

  function automatic logic [127:0] inv_shift_rows(logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = s;
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  function automatic logic [31:0] inv_mix_word(logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
            gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(logic [127:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]), inv_mix_word(s[31:0])};
  endfunction

  always_comb begin
    sword_in = '0;
    unique case (sword_ctr_q)
      2'd0: sword_in = block_q[127:96];
      2'd1: sword_in = block_q[95:64];
      2'd2: sword_in = block_q[63:32];
      2'd3: sword_in = block_q[31:0];
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (sword_in[8*i +: 8]),
      .out_byte (sword_out[8*i +: 8])
    );
  end

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    unique case (state_q)
      StIdle: begin
        if (host.next) begin
          block_d     = host.block;
          round_ctr_d = num_rounds(host.keylen);
          state_d     = StInit;
        end
      end
      StInit: begin
        block_d     = block_q ^ round_key;
        round_ctr_d = round_ctr_q - 4'd1;
        state_d     = StIsr;
      end
      StIsr: begin
        block_d     = inv_shift_rows(block_q);
        sword_ctr_d = '0;
        state_d     = StIsb;
      end
      StIsb: begin
        unique case (sword_ctr_q)
          2'd0: block_d[127:96] = sword_out;
          2'd1: block_d[95:64]  = sword_out;
          2'd2: block_d[63:32]  = sword_out;
          2'd3: block_d[31:0]   = sword_out;
        endcase
        sword_ctr_d = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) state_d = StArk;
      end
      StArk: begin
        // Round 0 is the final round: no InvMixColumns, and the counter stays at 0.
        if (round_ctr_q != 4'd0) begin
          block_d     = inv_mix_columns(block_q ^ round_key);
          round_ctr_d = round_ctr_q - 4'd1;
          state_d     = StIsr;
        end else begin
          block_d = block_q ^ round_key;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      block_q     <= '0;
      round_ctr_q <= '0;
      sword_ctr_q <= '0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
    end
  end

  assign host.new_block = block_q;
  assign host.ready     = (state_q == StIdle);
  assign round_key_addr = round_ctr_q;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Directed bench for aes_decipher_ctrl against FIPS-197 appendix C vectors.
module tb_aes_decipher_ctrl;

  logic         clk;
  logic         reset_n;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic [127:0] rk [16];
  logic [7:0]   sbox [256];
  int           total;
  int           bad;
  int           n;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_decipher_ctrl_if io ();

  aes_decipher_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .host           (io),
    .round_key_addr (round_key_addr),
    .round_key      (round_key)
  );

  always #5 clk = ~clk;

  // Key memory: combinational read of the expanded schedule.
  always_comb round_key = rk[round_key_addr];

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  // Forward S-box from brute-force inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key 00 01 02 ... of nk words, expanded per FIPS-197.
  task automatic load_keys(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a run and counts edges until ready; pa/pb are edges at which a stray next is sampled.
  task automatic run(input logic [127:0] ct, input logic [1:0] kl, input int pa, input int pb,
                     input bit tog, input bit trace, output int edges);
    int exp_addr;
    @(negedge clk);
    io.block  = ct;
    io.keylen = kl;
    io.next   = 1'b1;
    @(posedge clk);
    #1;
    edges    = 1;
    io.next  = (pa == 2) || (pb == 2);
    io.block = ~ct;
    if (trace) check("addr_init", 128'(round_key_addr), 128'(10));
    while (!io.ready && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      io.next = (edges + 1 == pa) || (edges + 1 == pb);
      if (tog) io.keylen = io.keylen + 2'd1;
      if (trace) begin
        exp_addr = (edges >= 62) ? 0 : 9 - (edges - 2) / 6;
        check($sformatf("addr_e%0d", edges), 128'(round_key_addr), 128'(exp_addr));
      end
    end
    io.next = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    total     = 0;
    bad       = 0;
    io.next   = 1'b0;
    io.keylen = 2'd0;
    io.block  = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    #12;
    check("rst_ready", 128'(io.ready), 128'(1));
    check("rst_block", io.new_block, 128'h0);
    check("rst_addr", 128'(round_key_addr), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // AES-128
    load_keys(4);
    run(CT_128, 2'd0, 0, 0, 1'b0, 1'b0, n);
    check("t1_lat", 128'(n), 128'(62));
    check("t1_pt", io.new_block, PT);

    // AES-192
    load_keys(6);
    run(CT_192, 2'd1, 0, 0, 1'b0, 1'b0, n);
    check("t2_lat", 128'(n), 128'(74));
    check("t2_pt", io.new_block, PT);

    // AES-256, with a stray next on the edge where ready rises
    load_keys(8);
    run(CT_256, 2'd2, 86, 0, 1'b0, 1'b0, n);
    check("t3_lat", 128'(n), 128'(86));
    check("t3_pt", io.new_block, PT);
    @(posedge clk);
    #1;
    check("t3_ready_hold", 128'(io.ready), 128'(1));
    check("t3_pt_hold", io.new_block, PT);

    // AES-128 address trace, ignored next pulses at edges 5 and 61
    load_keys(4);
    run(CT_128, 2'd0, 5, 61, 1'b0, 1'b1, n);
    check("t4_lat", 128'(n), 128'(62));
    check("t4_pt", io.new_block, PT);
    repeat (3) @(posedge clk);
    #1;
    check("t4_pt_hold", io.new_block, PT);
    check("t4_addr_idle", 128'(round_key_addr), 128'(0));

    // Reset at cycle 30 of an AES-128 run
    @(negedge clk);
    io.block  = CT_128;
    io.keylen = 2'd0;
    io.next   = 1'b1;
    @(posedge clk);
    #1;
    io.next = 1'b0;
    repeat (28) @(posedge clk);
    #3;
    check("t5_busy", 128'(io.ready), 128'(0));
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready", 128'(io.ready), 128'(1));
    check("t5_rst_block", io.new_block, 128'h0);
    check("t5_rst_addr", 128'(round_key_addr), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run(CT_128, 2'd0, 0, 0, 1'b0, 1'b0, n);
    check("t5_lat", 128'(n), 128'(62));
    check("t5_pt", io.new_block, PT);

    // Back-to-back AES-256 start on the cycle after ready rose; keylen toggles mid-run
    load_keys(8);
    run(CT_256, 2'd2, 0, 0, 1'b1, 1'b0, n);
    check("t6_lat", 128'(n), 128'(86));
    check("t6_pt", io.new_block, PT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
